instruction_queue: RTL and testbench

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue.sv | 120 ++++++++++++
 tb/tb_instruction_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruction_queue
// Description : Circular-buffer instruction queue between the control unit
//               and the issue stage. One push per cycle, up to three pops per
//               cycle, with the three oldest entries exposed at the head.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_queue #(
    parameter int LOG_DEPTH          = 4,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_we,
    input  logic [1:0]           push_instr_type,
    input  logic [13:0]          push_arith_instr,
    input  logic [8:0]           push_ram_instr,
    input  logic [9:0]           push_ld_st_instr,
    input  logic [17:0]          push_cache_addr,
    input  logic [17:0]          push_main_mem_addr,
    input  logic [17:0]          push_d_cache_addr,
    input  logic [17:0]          push_d_main_mem_addr,
    input  logic [1:0]           pop_cnt,
    output logic [2:0]           head_valid,
    output logic [320:0]         head_entry,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int c_ENTRY_W    = 107;
    localparam int c_HEAD_SLOTS = 3;
    localparam int c_CW         = LOG_DEPTH + 1;
    localparam int c_DEPTH      = 1 << LOG_DEPTH;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(c_DEPTH);
    localparam logic [c_CW-1:0] c_AF_THRESH = c_CW'(c_DEPTH - ALMOST_FULL_MARGIN);

    // Storage is deliberately left out of reset; count gates all visibility.
    logic [c_ENTRY_W-1:0] r_mem [c_DEPTH];
    logic [LOG_DEPTH-1:0] r_rd_ptr;
    logic [LOG_DEPTH-1:0] r_wr_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_CW-1:0]      w_pop_req;
    logic [c_CW-1:0]      w_eff_pop;
    logic [c_CW-1:0]      w_after_pop;
    logic                 w_push_acc;
    logic                 w_push_drop;
    logic                 w_pop_excess;
    logic [c_CW-1:0]      w_count_next;

    assign w_push_entry = {push_instr_type, push_arith_instr, push_ram_instr,
                           push_ld_st_instr, push_cache_addr, push_main_mem_addr,
                           push_d_cache_addr, push_d_main_mem_addr};

    // Pops are clamped to the current occupancy; the push check uses the
    // post-pop occupancy so a full queue can accept while draining.
    always_comb begin
        w_pop_req    = c_CW'(pop_cnt);
        w_pop_excess = (w_pop_req > r_count);
        w_eff_pop    = w_pop_excess ? r_count : w_pop_req;
        w_after_pop  = r_count - w_eff_pop;
        w_push_acc   = push_we && (w_after_pop < c_DEPTH_CNT);
        w_push_drop  = push_we && !w_push_acc;
        w_count_next = w_after_pop + c_CW'(w_push_acc);
    end

    // Pointer, occupancy and sticky error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + w_eff_pop[LOG_DEPTH-1:0];
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= w_count_next;
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop_excess) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Entry storage write; only accepted pushes touch the array.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Head window: oldest entries, zeroed when the slot holds nothing.
    for (genvar k = 0; k < c_HEAD_SLOTS; k++) begin : g_head_slot
        logic [LOG_DEPTH-1:0] w_idx;
        assign w_idx         = r_rd_ptr + LOG_DEPTH'(k);
        assign head_valid[k] = (r_count > c_CW'(k));
        assign head_entry[k*c_ENTRY_W +: c_ENTRY_W] = head_valid[k] ? r_mem[w_idx]
                                                                    : '0;
    end

    assign count       = r_count;
    assign full        = (r_count == c_DEPTH_CNT);
    assign almost_full = (r_count >= c_AF_THRESH);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_queue
// Description : Scoreboard bench for instruction_queue. Stimulus pushes the
//               expected entry when a push is accepted; a negedge monitor
//               pops and compares whenever the bench consumes head slots.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_queue;

    localparam int c_LD    = 4;
    localparam int c_DEPTH = 16;

    logic           clk;
    logic           reset;
    logic           push_we;
    logic [1:0]     push_instr_type;
    logic [13:0]    push_arith_instr;
    logic [8:0]     push_ram_instr;
    logic [9:0]     push_ld_st_instr;
    logic [17:0]    push_cache_addr;
    logic [17:0]    push_main_mem_addr;
    logic [17:0]    push_d_cache_addr;
    logic [17:0]    push_d_main_mem_addr;
    logic [1:0]     pop_cnt;
    logic [2:0]     head_valid;
    logic [320:0]   head_entry;
    logic [c_LD:0]  count;
    logic           full;
    logic           almost_full;
    logic           overflow;
    logic           underflow;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_popped = 0;

    logic [106:0] exp_q[$];
    int           m_count;
    bit           m_ovf;
    bit           m_unf;

    instruction_queue #(.LOG_DEPTH(c_LD), .ALMOST_FULL_MARGIN(2)) u_dut (
        .clk                  (clk),
        .reset                (reset),
        .push_we              (push_we),
        .push_instr_type      (push_instr_type),
        .push_arith_instr     (push_arith_instr),
        .push_ram_instr       (push_ram_instr),
        .push_ld_st_instr     (push_ld_st_instr),
        .push_cache_addr      (push_cache_addr),
        .push_main_mem_addr   (push_main_mem_addr),
        .push_d_cache_addr    (push_d_cache_addr),
        .push_d_main_mem_addr (push_d_main_mem_addr),
        .pop_cnt              (pop_cnt),
        .head_valid           (head_valid),
        .head_entry           (head_entry),
        .count                (count),
        .full                 (full),
        .almost_full          (almost_full),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Every field derived from cache_addr so packing errors show up.
    function automatic logic [106:0] make_entry(input logic [17:0] ca);
        return {ca[1:0], ca[6:0], ~ca[6:0], ca[8:0] ^ 9'h155, ca[9:0] + 10'd3,
                ca, ca + 18'h01000, ~ca, ca[15:0], 2'b00};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        logic [2:0] hv;
        hv = (m_count >= 3) ? 3'b111 : (m_count == 2) ? 3'b011 : (m_count == 1) ? 3'b001 : 3'b000;
        chk({tag, "_count"}, 128'(count), 128'(m_count));
        chk({tag, "_hv"}, 128'(head_valid), 128'(hv));
        chk({tag, "_full"}, 128'(full), 128'(m_count == c_DEPTH));
        chk({tag, "_afull"}, 128'(almost_full), 128'(m_count >= c_DEPTH - 2));
        chk({tag, "_ovf"}, 128'(overflow), 128'(m_ovf));
        chk({tag, "_unf"}, 128'(underflow), 128'(m_unf));
    endtask

    // One clock of stimulus; expected entry enters the scoreboard at the edge.
    task automatic step(input logic we, input logic [17:0] ca, input logic [1:0] pc);
        int eff;
        bit acc;
        push_we = we;
        {push_instr_type, push_arith_instr, push_ram_instr, push_ld_st_instr,
         push_cache_addr, push_main_mem_addr, push_d_cache_addr,
         push_d_main_mem_addr} = make_entry(ca);
        pop_cnt = pc;
        eff = (int'(pc) > m_count) ? m_count : int'(pc);
        acc = we && ((m_count - eff) < c_DEPTH);
        if (we && !acc) m_ovf = 1'b1;
        if (int'(pc) > m_count) m_unf = 1'b1;
        @(posedge clk);
        if (acc) exp_q.push_back(make_entry(ca));
        m_count = m_count - eff + int'(acc);
        #1;
        push_we = 1'b0;
        pop_cnt = 2'd0;
    endtask

    // Monitor: consumed head slots must match the oldest scoreboard entries.
    always @(negedge clk) begin : mon
        int n;
        logic [106:0] e;
        if (reset) begin
            n = (int'(pop_cnt) > exp_q.size()) ? exp_q.size() : int'(pop_cnt);
            for (int k = 0; k < n; k++) begin
                e = exp_q.pop_front();
                chk("pop_entry", 128'(head_entry[k*107 +: 107]), 128'(e));
                chk("pop_valid", 128'(head_valid[k]), 128'(1));
                n_popped++;
            end
        end
    end

    initial begin
        int pushed;
        int iter;
        int pc;
        int base_popped;
        bit we;
        reset = 1'b1;
        push_we = 1'b0;
        pop_cnt = 2'd0;
        {push_instr_type, push_arith_instr, push_ram_instr, push_ld_st_instr,
         push_cache_addr, push_main_mem_addr, push_d_cache_addr,
         push_d_main_mem_addr} = '0;
        m_count = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_hv", 128'(head_valid), 128'(0));
        chk("rst_entry", 128'(head_entry), 128'(0));
        chk("rst_flags", 128'({full, almost_full, overflow, underflow}), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Fill to 16: almost_full at 14, full at 16
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 18'(i), 2'd0);
            chk_state("fill");
            if (i == 12) chk("afull_13", 128'(almost_full), 128'(0));
            if (i == 13) chk("afull_14", 128'(almost_full), 128'(1));
            if (i == 14) chk("full_15", 128'(full), 128'(0));
        end
        chk("full_16", 128'(full), 128'(1));

        // Push with pop on a full queue is accepted
        step(1'b1, 18'd100, 2'd1);
        chk_state("fullpp");
        chk("fullpp_count", 128'(count), 128'(16));
        chk("fullpp_ovf", 128'(overflow), 128'(0));

        // 17th push dropped
        step(1'b1, 18'd200, 2'd0);
        chk_state("drop");
        chk("drop_ovf", 128'(overflow), 128'(1));
        chk("drop_count", 128'(count), 128'(16));

        // Drain: entries 1..15 then 100
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 18'd0, 2'd3);
            chk_state("drain");
        end
        step(1'b0, 18'd0, 2'd1);
        chk_state("drain");
        chk("drain_sb_empty", 128'(exp_q.size()), 128'(0));

        // A,B,C,D then pop 3
        for (int i = 1; i <= 4; i++) step(1'b1, 18'(i), 2'd0);
        chk("abcd_hv", 128'(head_valid), 128'(3'b111));
        chk("abcd_s0", 128'(head_entry[0 +: 107]), 128'(make_entry(18'd1)));
        chk("abcd_s1", 128'(head_entry[107 +: 107]), 128'(make_entry(18'd2)));
        chk("abcd_s2", 128'(head_entry[214 +: 107]), 128'(make_entry(18'd3)));
        step(1'b0, 18'd0, 2'd3);
        chk("pop3_hv", 128'(head_valid), 128'(3'b001));
        chk("pop3_s0", 128'(head_entry[0 +: 107]), 128'(make_entry(18'd4)));
        chk("pop3_count", 128'(count), 128'(1));

        // Over-pop with one entry
        step(1'b0, 18'd0, 2'd3);
        chk("unf_count", 128'(count), 128'(0));
        chk("unf_hv", 128'(head_valid), 128'(0));
        chk("unf_flag", 128'(underflow), 128'(1));
        chk("unf_entry", 128'(head_entry), 128'(0));

        // Push and pop together on an empty queue
        step(1'b1, 18'd50, 2'd1);
        chk("emptypp_count", 128'(count), 128'(1));
        chk("emptypp_s0", 128'(head_entry[0 +: 107]), 128'(make_entry(18'd50)));
        chk_state("emptypp");

        // Fill to 7 then asynchronous reset between edges
        for (int i = 0; i < 6; i++) step(1'b1, 18'(300 + i), 2'd0);
        chk("pre_rst_count", 128'(count), 128'(7));
        #2 reset = 1'b0;
        #2;
        chk("arst_count", 128'(count), 128'(0));
        chk("arst_hv", 128'(head_valid), 128'(0));
        chk("arst_entry", 128'(head_entry), 128'(0));
        chk("arst_flags", 128'({full, almost_full, overflow, underflow}), 128'(0));
        exp_q.delete();
        m_count = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // First push after reset lands in slot 0
        step(1'b1, 18'd77, 2'd0);
        chk("post_rst_s0", 128'(head_entry[0 +: 107]), 128'(make_entry(18'd77)));
        chk("post_rst_hv", 128'(head_valid), 128'(3'b001));
        step(1'b0, 18'd0, 2'd1);
        chk_state("post_rst");

        // Random interleaved push/pop of 40 entries, crossing the wrap
        pushed = 0;
        iter = 0;
        base_popped = n_popped;
        while ((pushed < 40 || m_count > 0) && iter < 400) begin
            pc = $urandom_range(0, (m_count < 3) ? m_count : 3);
            we = (pushed < 40) && ($urandom_range(0, 3) != 0) && ((m_count - pc) < c_DEPTH);
            step(we, 18'(pushed), 2'(pc));
            if (we) pushed++;
            iter++;
            chk_state("rand");
        end
        chk("rand_done", 128'(iter < 400), 128'(1));
        chk("rand_popped", 128'(n_popped - base_popped), 128'(40));
        chk("rand_flags", 128'({overflow, underflow}), 128'(0));
        chk("rand_sb_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
